vga_line_fetch: RTL
===================

Name: vga_line_fetch

Overview:
Pixel source stage that sits between vga_sync and vga_display. It consumes the sync counters and data-enable, prefetches each visible line from a framebuffer over a simple memory read port into a ping-pong line buffer, and presents registered RGB aligned to the counters for vga_display to pass through. Any framebuffer source with an in-order read interface can drive the screen through it.

Parameters:
H_ACTIVE, 640, visible pixels per line
V_ACTIVE, 480, visible lines per frame
H_ACT_START, 144, h_counter value of the first visible pixel
V_ACT_START, 35, v_counter value of the first visible line
ADDR_W, 20, memory word-address width
FB_BASE, 0, word address of pixel (0,0); one 24-bit word per pixel, row-major

Ports:
clk  in  1  pixel clock (video_clk)
rst_n  in  1  asynchronous active-low reset
h_counter  in  12  horizontal counter from vga_sync
v_counter  in  12  vertical counter from vga_sync
video_active  in  1  data enable from vga_sync
mem_req  out  1  read request valid
mem_addr  out  ADDR_W  read word address
mem_ready  in  1  request accepted when mem_req&&mem_ready
mem_rvalid  in  1  read data valid; responses return in order
mem_rdata  in  24  {R,G,B} read data
clear_underrun  in  1  clears the underrun flag
pix_r  out  8  red to vga_display
pix_g  out  8  green to vga_display
pix_b  out  8  blue to vga_display
pix_valid  out  1  video_active delayed one clock
underrun  out  1  sticky flag: a fetch was still in progress at the next trigger

Behaviour:
- Reset (async assert, sync release): mem_req=0, mem_addr=0, pix_*=0, pix_valid=0, underrun=0, FSM=IDLE, line_base=FB_BASE, all counters 0.
- Fetch triggers, sampled at h_counter==0:
  - Frame trigger: v_counter==V_ACT_START-1. Fetch line 0 into buffer 0. line_base=FB_BASE.
  - Line trigger: v_counter==V_ACT_START+y, with y<V_ACTIVE-1. Fetch line y+1 into buffer (y+1)&1. line_base+=H_ACTIVE.
  - No fetch is triggered during the last visible line.
- FSM:
  - IDLE: on trigger -> REQ. Load req_cnt=0 and rsp_cnt=0.
  - REQ: mem_req=1, mem_addr=line_base+req_cnt. On each accept, req_cnt++. When the accept makes req_cnt reach H_ACTIVE, drop mem_req -> DRAIN.
  - DRAIN: wait until rsp_cnt==H_ACTIVE, then -> IDLE.
  - Responses: each mem_rvalid writes buffer[sel][rsp_cnt] and increments rsp_cnt. This happens in both REQ and DRAIN, and may coincide with accepts in the same cycle.
  - mem_addr is held stable while mem_req&&!mem_ready.
- Trigger while not IDLE: set underrun, ignore the trigger, let the current fetch complete. The affected line shows stale buffer contents.
- clear_underrun clears underrun. If it coincides with a new underrun event, set wins.
- Display path:
  - Read address x=h_counter-H_ACT_START, buffer (v_counter-V_ACT_START)&1, sampled every cycle.
  - Synchronous RAM gives one-clock latency. pix_* appear one clock after the corresponding counters.
  - pix_valid = video_active registered one clock. pix_*=0 whenever pix_valid would be 0.
- Width rules: x and y are computed in 12 bits. line_base has ADDR_W bits and wraps modulo 2^ADDR_W.
- Fetch and display never touch the same buffer half in the same line, so no read/write collision handling is required.

Decomposition:
- vga_timing_pkg holds H_ACTIVE, V_ACTIVE, H_ACT_START, V_ACT_START and the FSM state encoding (IDLE, REQ, DRAIN). vga_sync and vga_display import the same package.
- One sub-module: line_buffer_dp. It is a simple dual-port RAM, 2*H_ACTIVE x 24: one write port (fetch), one registered read port (display), single clock.

Test Plan:
- Memory model in all scenarios: rdata = addr[23:0], fixed latency 3, mem_ready=1 unless stated.
- Reset: hold rst_n=0 with counters running -> all outputs 0. Release -> no mem_req until v_counter=34, h_counter=0.
- Frame fetch: at v=34, h=0 -> mem_req rises. Exactly 640 accepts with addresses 0..639, then mem_req=0. FSM returns to IDLE after the 640th rvalid, well before v=35.
- Display alignment: v=35, h=149 (x=5) -> next clock pix_valid=1, {pix_r,pix_g,pix_b}=24'h000005. At h=143 -> pix_*=0.
- Ping-pong: line 1 fetch during v=35 uses addresses 640..1279. At v=36, x=0 -> pixel 24'h000280. No fetch during v=514. The next frame restarts at address 0.
- Backpressure/underrun: mem_ready random 50% -> line data still correct and mem_addr held while stalled. Then response latency 900 cycles -> underrun=1 at the next trigger. Pulse clear_underrun -> underrun=0.
- Reset mid-fetch: assert rst_n=0 when req_cnt=300 -> mem_req=0 immediately, FSM IDLE. The next frame fetches addresses 0..639 correctly.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants and the line-fetch FSM encoding.
// vga_sync, vga_line_fetch and vga_display all import this package.
package vga_timing_pkg;

    localparam int H_ACTIVE    = 640;
    localparam int V_ACTIVE    = 480;
    localparam int H_ACT_START = 144;
    localparam int V_ACT_START = 35;

    // Two line halves back to back: half 0 at [0, H_ACTIVE), half 1 above it.
    localparam int LB_DEPTH = 2 * H_ACTIVE;
    localparam int LB_AW    = $clog2(LB_DEPTH);
    // Request/response counters must be able to hold H_ACTIVE itself.
    localparam int CNT_W    = $clog2(H_ACTIVE + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/vga_line_fetch_if.sv
// In-order framebuffer read port: request/accept handshake plus a
// response strobe that returns data in request order.
interface vga_line_fetch_if #(
    parameter int ADDR_W = 20
);
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ready;
    logic              mem_rvalid;
    logic [23:0]       mem_rdata;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ready,
        input  mem_rvalid,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ready,
        output mem_rvalid,
        output mem_rdata
    );
endinterface

// File: rtl/vga_line_fetch_line_buffer.sv
// Simple dual-port line RAM: one write port for the fetch side, one
// registered read port for the display side, single clock.
module line_buffer_dp #(
    parameter int DEPTH = 1280,
    parameter int AW    = 11,
    parameter int DW    = 24
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [DEPTH];
    logic [DW-1:0] r_rdata;

    // Fetch side writes one pixel per returned memory word.
    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    // Display side read with one clock of latency; RAM content is not reset.
    always_ff @(posedge clk) begin
        r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/vga_line_fetch.sv
// Line prefetcher between vga_sync and vga_display. At h_counter==0 of the
// line before each visible line it reads that line from the framebuffer
// into one half of a ping-pong buffer while the other half is displayed.
module vga_line_fetch
    import vga_timing_pkg::*;
#(
    parameter int          ADDR_W  = 20,
    parameter int unsigned FB_BASE = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [11:0]         h_counter,
    input  logic [11:0]         v_counter,
    input  logic                video_active,
    vga_line_fetch_if.master    mem,
    input  logic                clear_underrun,
    output logic [7:0]          pix_r,
    output logic [7:0]          pix_g,
    output logic [7:0]          pix_b,
    output logic                pix_valid,
    output logic                underrun
);

    logic [11:0]       w_x;
    logic [11:0]       w_y;
    logic              w_frame_trig;
    logic              w_line_trig;
    logic              w_trig;
    logic              w_start;
    logic              w_accept;
    logic              w_rsp;
    logic [LB_AW-1:0]  w_waddr;
    logic [LB_AW-1:0]  w_raddr;
    logic [23:0]       w_rdata;

    fetch_state_t      r_state;
    fetch_state_t      w_next;
    logic [CNT_W-1:0]  r_req_cnt;
    logic [CNT_W-1:0]  r_rsp_cnt;
    logic [ADDR_W-1:0] r_line_base;
    logic              r_sel;
    logic              r_underrun;
    logic              r_pix_valid;

    // Both coordinates wrap in 12 bits, so out-of-window counters land far
    // above the active range and fail the range compares below.
    assign w_x = h_counter - 12'(H_ACT_START);
    assign w_y = v_counter - 12'(V_ACT_START);

    // Frame trigger loads line 0; line triggers run during visible line y and
    // load y+1, except during the last visible line.
    assign w_frame_trig = (h_counter == 12'd0) && (v_counter == 12'(V_ACT_START - 1));
    assign w_line_trig  = (h_counter == 12'd0) && (w_y < 12'(V_ACTIVE - 1));
    assign w_trig       = w_frame_trig || w_line_trig;
    assign w_start      = w_trig && (r_state == IDLE);

    assign w_accept = (r_state == REQ) && mem.mem_ready;
    assign w_rsp    = mem.mem_rvalid && (r_state != IDLE) &&
                      (r_rsp_cnt < CNT_W'(H_ACTIVE));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Next state and memory request outputs; the address is a pure function
    // of registered state so it stays put while a request is stalled.
    always_comb begin
        w_next       = r_state;
        mem.mem_req  = 1'b0;
        mem.mem_addr = '0;
        case (r_state)
            IDLE: begin
                if (w_trig) w_next = REQ;
            end
            REQ: begin
                mem.mem_req  = 1'b1;
                mem.mem_addr = r_line_base + ADDR_W'(r_req_cnt);
                if (w_accept && (r_req_cnt == CNT_W'(H_ACTIVE - 1))) w_next = DRAIN;
            end
            DRAIN: begin
                if (r_rsp_cnt == CNT_W'(H_ACTIVE)) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Fetch bookkeeping: line base, target half, request/response counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req_cnt   <= '0;
            r_rsp_cnt   <= '0;
            r_line_base <= ADDR_W'(FB_BASE);
            r_sel       <= 1'b0;
        end else if (w_start) begin
            r_req_cnt <= '0;
            r_rsp_cnt <= '0;
            if (w_frame_trig) begin
                r_line_base <= ADDR_W'(FB_BASE);
                r_sel       <= 1'b0;
            end else begin
                r_line_base <= r_line_base + ADDR_W'(H_ACTIVE);
                r_sel       <= ~w_y[0];
            end
        end else begin
            if (w_accept) r_req_cnt <= r_req_cnt + 1'b1;
            if (w_rsp)    r_rsp_cnt <= r_rsp_cnt + 1'b1;
        end
    end

    // Sticky underrun: a trigger found the previous fetch still busy.
    // A new event beats a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                          r_underrun <= 1'b0;
        else if (w_trig && r_state != IDLE)  r_underrun <= 1'b1;
        else if (clear_underrun)             r_underrun <= 1'b0;
    end

    // Data enable delayed to match the RAM read latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_pix_valid <= 1'b0;
        else        r_pix_valid <= video_active;
    end

    assign w_waddr = (r_sel ? LB_AW'(H_ACTIVE) : LB_AW'(0)) + LB_AW'(r_rsp_cnt);
    assign w_raddr = (w_x < 12'(H_ACTIVE)) ?
                     ((w_y[0] ? LB_AW'(H_ACTIVE) : LB_AW'(0)) + LB_AW'(w_x)) :
                     LB_AW'(0);

    line_buffer_dp #(
        .DEPTH (LB_DEPTH),
        .AW    (LB_AW),
        .DW    (24)
    ) u_lbuf (
        .clk     (clk),
        .i_we    (w_rsp),
        .i_waddr (w_waddr),
        .i_wdata (mem.mem_rdata),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata)
    );

    // Blank RGB outside the active window so vga_display sees clean zeros.
    assign pix_r     = r_pix_valid ? w_rdata[23:16] : 8'd0;
    assign pix_g     = r_pix_valid ? w_rdata[15:8]  : 8'd0;
    assign pix_b     = r_pix_valid ? w_rdata[7:0]   : 8'd0;
    assign pix_valid = r_pix_valid;
    assign underrun  = r_underrun;

endmodule
